dense_layer_seq: RTL and testbench
==================================

Name: dense_layer_seq

Overview:
- Parametrised, weight-programmable fully-connected layer engine. Successor to dense_top, which was fixed to 7 outputs with no backpressure.
- Accepts an input vector as NUM_BEATS beats of NUMI_ONCE signed samples, over a valid/ready handshake.
- Time-multiplexes one NUMI_ONCE-wide MAC array across NUM_OUT neurons, then emits requantised, optionally ReLU'd results.
- Sits after the conv/pool feature stage and feeds the classifier argmax.

Parameters:
- DATA_WIDTH, 8: bit width of each signed input sample, weight and output.
- NUMI_ONCE, 36: samples per input beat; also the MAC array width.
- NUM_BEATS, 3: beats per input vector, so the vector length is NUMI_ONCE*NUM_BEATS.
- NUM_OUT, 7: number of output neurons.
- ACC_WIDTH, 24: signed accumulator width. Must be >= 2*DATA_WIDTH + clog2(NUMI_ONCE*NUM_BEATS) + 1, so no overflow can occur.
- RELU_EN, 1: 1 clamps negative results to 0 before saturation; 0 gives a linear output.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- data_i  in  DATA_WIDTH*NUMI_ONCE  input beat. Sample j is data_i[j*DATA_WIDTH+:DATA_WIDTH], signed.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  engine can accept a beat this cycle.
- w_we  in  1  weight write enable.
- w_addr  in  clog2(NUM_BEATS*NUM_OUT)  weight row address = beat*NUM_OUT + neuron.
- w_data  in  DATA_WIDTH*NUMI_ONCE  weight row, laid out like data_i.
- b_we  in  1  bias write enable.
- b_addr  in  clog2(NUM_OUT)  bias index.
- b_data  in  ACC_WIDTH  signed bias, added in the accumulator domain.
- shift_i  in  5  arithmetic right shift applied at requantisation. Quasi-static; sampled in state OUT.
- clear_i  in  1  synchronous abort of the current vector.
- data_o  out  DATA_WIDTH*NUM_OUT  result. Neuron n is data_o[n*DATA_WIDTH+:DATA_WIDTH], signed.
- valid_o  out  1  one-cycle result strobe.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, beat_cnt=0, neuron_cnt=0, all accumulators=0.
  - ready_o=0 while in reset; ready_o=1 from the first clock edge after deassertion.
  - data_o=0, valid_o=0.
  - Weight and bias storage is not reset.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: register data_i into the beat buffer, set neuron_cnt=0, go to MAC.
  - valid_i while ready_o=0 is not accepted. The source holds the beat until a handshake occurs.
- MAC (exactly NUM_OUT cycles, ready_o=0):
  - Each cycle: acc[neuron_cnt] = base + sum over j of signed(x_j)*signed(W[beat_cnt*NUM_OUT+neuron_cnt]_j).
  - base is bias[neuron_cnt] when beat_cnt==0, otherwise acc[neuron_cnt].
  - Products are full 2*DATA_WIDTH wide and sign-extended to ACC_WIDTH.
  - neuron_cnt increments each cycle. After neuron NUM_OUT-1:
    - if beat_cnt==NUM_BEATS-1, go to OUT;
    - otherwise beat_cnt++ and go to IDLE.
- OUT (1 cycle, ready_o=0):
  - For each neuron: r = acc >>> shift_i; if RELU_EN and r<0 then r=0; saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register the results into data_o and pulse valid_o=1 on the following cycle only.
  - Set beat_cnt=0 and go to IDLE.
- Latency:
  - A beat accepted at edge T is back in IDLE with ready_o=1 after edge T+NUM_OUT. Intermediate beats: at most 1 beat per NUM_OUT+1 cycles.
  - For the last beat, valid_o is high in the cycle after edge T+NUM_OUT+1 and ready_o=1 in that same cycle.
- data_o holds its value until the next OUT state; it is not cleared by clear_i.
- clear_i=1 at any edge:
  - next state IDLE, beat_cnt=0, neuron_cnt=0, no valid_o pulse.
  - clear_i has priority over a simultaneous valid_i handshake; that beat is dropped.
- Weight and bias writes:
  - Take effect at the edge only when state==IDLE and there is no handshake on the same edge. Otherwise they are silently dropped.
  - w_addr >= NUM_BEATS*NUM_OUT and b_addr >= NUM_OUT are ignored.
- Reset mid-vector: the partial vector is discarded and there is no valid_o pulse. The next accepted beat is treated as beat 0.

Test Plan:
- Program all weights=1, all biases=0, shift_i=1. Send beats of all 1s, all 2s, all 3s (valid_i high for one cycle each, resent after ready_o) -> exactly one valid_o pulse; every data_o byte = 0x6C (216>>1=108).
- Same stimulus with shift_i=0 -> every byte = 0x7F (saturated from 216).
- Weights=-1 (0xFF), shift_i=1, RELU_EN=1 -> all bytes 0x00. Repeat with RELU_EN=0 -> all bytes 0x94 (-108).
- Per-neuron check: bias[n]=n*2, other inputs as in scenario 1 -> byte n = (216+2n)>>1 = 108+n, i.e. 0x6C..0x72.
- Hold valid_i high continuously:
  - ready_o low for exactly NUM_OUT=7 cycles after each intermediate handshake, 8 after the last;
  - exactly 3 beats consumed per vector; valid_o pulses once per 3 beats;
  - a write with w_we during MAC leaves the weights unchanged.
- Assert clear_i, or drop rstn, after beat 1 -> no valid_o pulse. A subsequent full 3-beat vector yields the scenario-1 result, 0x6C.

Source files
------------

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: weight-programmable fully-connected layer engine.
// One NUMI_ONCE-wide MAC array is time-multiplexed over NUM_OUT neurons.
// An input vector arrives as NUM_BEATS beats over a valid/ready handshake.
// After the last beat, every accumulator is requantised (arithmetic shift,
// optional ReLU, saturation) and emitted with a one-cycle valid_o strobe.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   data_i/valid_i   input beat (sample j at [j*DATA_WIDTH +: DATA_WIDTH])
//   ready_o          a beat can be accepted this cycle
//   w_we/w_addr      weight row write, row = beat*NUM_OUT + neuron
//   w_data           weight row, laid out like data_i
//   b_we/b_addr      bias write, b_data is in the accumulator domain
//   shift_i          requantisation right shift, sampled in OUT
//   clear_i          synchronous abort of the current vector
//   data_o/valid_o   results (neuron n at [n*DATA_WIDTH +: DATA_WIDTH]), strobe
module dense_layer_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int NUMI_ONCE  = 36,
  parameter int NUM_BEATS  = 3,
  parameter int NUM_OUT    = 7,
  parameter int ACC_WIDTH  = 24,
  parameter int RELU_EN    = 1
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [DATA_WIDTH*NUMI_ONCE-1:0]         data_i,
  input  logic                                    valid_i,
  output logic                                    ready_o,
  input  logic                                    w_we,
  input  logic [$clog2(NUM_BEATS*NUM_OUT)-1:0]    w_addr,
  input  logic [DATA_WIDTH*NUMI_ONCE-1:0]         w_data,
  input  logic                                    b_we,
  input  logic [$clog2(NUM_OUT)-1:0]              b_addr,
  input  logic [ACC_WIDTH-1:0]                    b_data,
  input  logic [4:0]                              shift_i,
  input  logic                                    clear_i,
  output logic [DATA_WIDTH*NUM_OUT-1:0]           data_o,
  output logic                                    valid_o
);

  localparam int NROWS = NUM_BEATS * NUM_OUT;
  localparam int WA_W  = $clog2(NROWS);
  localparam int BC_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int NC_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int PW    = 2 * DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                          state;
  logic [BC_W-1:0]                     beat_cnt;
  logic [NC_W-1:0]                     neuron_cnt;
  logic [DATA_WIDTH*NUMI_ONCE-1:0]     x_buf;
  logic signed [ACC_WIDTH-1:0]         acc   [NUM_OUT];
  logic [DATA_WIDTH*NUMI_ONCE-1:0]     w_mem [NROWS];
  logic signed [ACC_WIDTH-1:0]         b_mem [NUM_OUT];

  logic                                hs;
  logic                                wr_ok;
  logic [WA_W-1:0]                     row;
  logic [DATA_WIDTH*NUMI_ONCE-1:0]     w_row;
  logic signed [ACC_WIDTH-1:0]         base;
  logic signed [PW-1:0]                prod;
  logic signed [ACC_WIDTH-1:0]         mac_sum;
  logic signed [ACC_WIDTH-1:0]         r;
  logic [DATA_WIDTH*NUM_OUT-1:0]       res;
  logic                                last_neuron;
  logic                                last_beat;

  // ready_o is a register that is only ever high while state is IDLE,
  // so it alone qualifies the handshake.
  assign hs          = valid_i && ready_o;
  assign wr_ok       = (state == S_IDLE) && !hs;
  assign last_neuron = (neuron_cnt == NC_W'(NUM_OUT - 1));
  assign last_beat   = (beat_cnt == BC_W'(NUM_BEATS - 1));
  assign row         = WA_W'(beat_cnt) * WA_W'(NUM_OUT) + WA_W'(neuron_cnt);

  // Weight and bias storage: no reset, writes only while idle and quiet.
  always_ff @(posedge clk) begin
    if (wr_ok && w_we && (32'(w_addr) < NROWS))
      w_mem[w_addr] <= w_data;
    if (wr_ok && b_we && (32'(b_addr) < NUM_OUT))
      b_mem[b_addr] <= b_data;
  end

  // One neuron's dot product over the current beat.
  always_comb begin
    w_row   = w_mem[row];
    base    = (beat_cnt == '0) ? b_mem[neuron_cnt] : acc[neuron_cnt];
    prod    = '0;
    mac_sum = base;
    for (int unsigned j = 0; j < NUMI_ONCE; j++) begin
      prod    = $signed(x_buf[j*DATA_WIDTH +: DATA_WIDTH]) *
                $signed(w_row[j*DATA_WIDTH +: DATA_WIDTH]);
      mac_sum = mac_sum + $signed({{(ACC_WIDTH-PW){prod[PW-1]}}, prod});
    end
  end

  // Requantisation: shift, optional ReLU, then saturate to DATA_WIDTH.
  always_comb begin
    res = '0;
    r   = '0;
    for (int unsigned n = 0; n < NUM_OUT; n++) begin
      r = acc[n] >>> shift_i;
      if ((RELU_EN != 0) && (r < 0))
        r = '0;
      if (r > SAT_MAX)
        r = SAT_MAX;
      else if (r < SAT_MIN)
        r = SAT_MIN;
      res[n*DATA_WIDTH +: DATA_WIDTH] = r[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      neuron_cnt <= '0;
      ready_o    <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      x_buf      <= '0;
      for (int unsigned n = 0; n < NUM_OUT; n++)
        acc[n] <= '0;
    end else begin
      valid_o <= 1'b0;
      if (clear_i) begin
        state      <= S_IDLE;
        beat_cnt   <= '0;
        neuron_cnt <= '0;
        ready_o    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (hs) begin
              x_buf      <= data_i;
              neuron_cnt <= '0;
              state      <= S_MAC;
              ready_o    <= 1'b0;
            end else begin
              ready_o    <= 1'b1;
            end
          end
          S_MAC: begin
            acc[neuron_cnt] <= mac_sum;
            if (last_neuron) begin
              neuron_cnt <= '0;
              if (last_beat) begin
                state   <= S_OUT;
                ready_o <= 1'b0;
              end else begin
                beat_cnt <= beat_cnt + BC_W'(1);
                state    <= S_IDLE;
                ready_o  <= 1'b1;
              end
            end else begin
              neuron_cnt <= neuron_cnt + NC_W'(1);
            end
          end
          S_OUT: begin
            data_o   <= res;
            valid_o  <= 1'b1;
            beat_cnt <= '0;
            state    <= S_IDLE;
            ready_o  <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: one ReLU instance and one linear
// instance share all inputs; expected results are hand-computed constants.
module tb_dense_layer_seq;

  localparam int DW = 8;
  localparam int NI = 36;
  localparam int NB = 3;
  localparam int NO = 7;
  localparam int AW = 24;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DW*NI-1:0]  data_i = '0;
  logic              valid_i = 1'b0;
  logic              w_we = 1'b0;
  logic [4:0]        w_addr = '0;
  logic [DW*NI-1:0]  w_data = '0;
  logic              b_we = 1'b0;
  logic [2:0]        b_addr = '0;
  logic [AW-1:0]     b_data = '0;
  logic [4:0]        shift_i = 5'd1;
  logic              clear_i = 1'b0;

  logic              ready_o, l_ready;
  logic [DW*NO-1:0]  data_o, l_data;
  logic              valid_o, l_valid;

  int                n_cmp = 0;
  int                n_bad = 0;
  int                pulses = 0;
  int                l_pulses = 0;
  logic [DW*NO-1:0]  cap_r = '0;
  logic [DW*NO-1:0]  cap_l = '0;

  always #5 clk = ~clk;

  dense_layer_seq #(.DATA_WIDTH(DW), .NUMI_ONCE(NI), .NUM_BEATS(NB),
                    .NUM_OUT(NO), .ACC_WIDTH(AW), .RELU_EN(1)) dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .shift_i(shift_i),
    .clear_i(clear_i), .data_o(data_o), .valid_o(valid_o)
  );

  dense_layer_seq #(.DATA_WIDTH(DW), .NUMI_ONCE(NI), .NUM_BEATS(NB),
                    .NUM_OUT(NO), .ACC_WIDTH(AW), .RELU_EN(0)) dut_lin (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
    .ready_o(l_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .shift_i(shift_i),
    .clear_i(clear_i), .data_o(l_data), .valid_o(l_valid)
  );

  always @(negedge clk) begin
    if (valid_o) begin
      pulses = pulses + 1;
      cap_r  = data_o;
    end
    if (l_valid) begin
      l_pulses = l_pulses + 1;
      cap_l    = l_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prog_w(input logic [7:0] v);
    for (int r = 0; r < NB*NO; r++) begin
      w_we   = 1'b1;
      w_addr = 5'(r);
      w_data = {NI{v}};
      @(negedge clk);
    end
    w_we = 1'b0;
  endtask

  task automatic prog_b(input int step);
    for (int n = 0; n < NO; n++) begin
      b_we   = 1'b1;
      b_addr = 3'(n);
      b_data = AW'(n * step);
      @(negedge clk);
    end
    b_we = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 40 && !ready_o; i++) @(negedge clk);
    if (!ready_o) check({tag, " ready timeout"}, 64'(ready_o), 64'd1);
  endtask

  task automatic send_beat(input logic [7:0] v);
    wait_ready("beat");
    data_i  = {NI{v}};
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check("ready low after accept", 64'(ready_o), 64'd0);
    check("lin ready low after accept", 64'(l_ready), 64'd0);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [DW*NO-1:0] e_r,
                         input logic [DW*NO-1:0] e_l);
    int p0, l0;
    p0 = pulses;
    l0 = l_pulses;
    send_beat(b0);
    send_beat(b1);
    send_beat(b2);
    for (int i = 0; i < 40 && pulses == p0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, " pulses"}, 64'(pulses - p0), 64'd1);
    check({tag, " lin pulses"}, 64'(l_pulses - l0), 64'd1);
    check({tag, " relu data"}, 64'(cap_r), 64'(e_r));
    check({tag, " lin data"}, 64'(cap_l), 64'(e_l));
  endtask

  initial begin
    logic [DW*NO-1:0] e;
    int runs, lowlen, hs, p0;
    int lows [6];
    int exp_lows [6];

    #1;
    @(negedge clk);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset valid", 64'(valid_o), 64'd0);
    check("reset data", 64'(data_o), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready after first edge", 64'(ready_o), 64'd1);

    // 216 >>> 1 = 108
    prog_w(8'h01);
    prog_b(0);
    shift_i = 5'd1;
    run_vec("ones shift1", 8'd1, 8'd2, 8'd3, {NO{8'h6C}}, {NO{8'h6C}});

    shift_i = 5'd0;
    run_vec("ones shift0 sat", 8'd1, 8'd2, 8'd3, {NO{8'h7F}}, {NO{8'h7F}});

    // -216 >>> 1 = -108 = 0x94; ReLU clamps to 0
    shift_i = 5'd1;
    prog_w(8'hFF);
    run_vec("neg weights", 8'd1, 8'd2, 8'd3, {NO{8'h00}}, {NO{8'h94}});

    // (216 + 2n) >>> 1 = 108 + n
    prog_w(8'h01);
    prog_b(2);
    for (int n = 0; n < NO; n++) e[n*DW +: DW] = 8'(108 + n);
    run_vec("per-neuron bias", 8'd1, 8'd2, 8'd3, e, e);
    prog_b(0);

    // Continuous valid with a weight write held during the whole run.
    exp_lows = '{7, 7, 8, 7, 7, 8};
    wait_ready("stream");
    p0      = pulses;
    runs    = 0;
    lowlen  = 0;
    hs      = 0;
    data_i  = {NI{8'h02}};
    valid_i = 1'b1;
    w_we    = 1'b1;
    w_addr  = 5'd0;
    w_data  = {NI{8'h05}};
    for (int c = 0; c < 300 && runs < 6; c++) begin
      if (ready_o) begin
        if (lowlen != 0) begin
          lows[runs] = lowlen;
          runs++;
          lowlen = 0;
        end
        if (runs < 6) hs++;
      end else begin
        lowlen++;
      end
      if (runs < 6) @(negedge clk);
    end
    valid_i = 1'b0;
    w_we    = 1'b0;
    if (runs < 6) check("stream run timeout", 64'(runs), 64'd6);
    for (int i = 0; i < 6; i++) check("stream ready-low length", 64'(lows[i]), 64'(exp_lows[i]));
    check("stream beats consumed", 64'(hs), 64'd6);
    repeat (3) @(negedge clk);
    check("stream pulses", 64'(pulses - p0), 64'd2);
    check("stream data after dropped write", 64'(cap_r), 64'({NO{8'h6C}}));

    // Clear during MAC of beat 0 of a vector.
    p0 = pulses;
    send_beat(8'd3);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("data held over clear", 64'(data_o), 64'({NO{8'h6C}}));
    run_vec("after clear", 8'd1, 8'd2, 8'd3, {NO{8'h6C}}, {NO{8'h6C}});
    check("clear total pulses", 64'(pulses - p0), 64'd1);

    // Clear coincident with a handshake drops that beat.
    wait_ready("clr hs");
    data_i  = {NI{8'd3}};
    valid_i = 1'b1;
    clear_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    clear_i = 1'b0;
    check("ready after clear+valid", 64'(ready_o), 64'd1);
    run_vec("clear beats handshake", 8'd1, 8'd2, 8'd3, {NO{8'h6C}}, {NO{8'h6C}});

    // Reset after beat 1 discards the partial vector.
    p0 = pulses;
    send_beat(8'd3);
    send_beat(8'd3);
    rstn = 1'b0;
    @(negedge clk);
    check("ready in mid reset", 64'(ready_o), 64'd0);
    check("data cleared by reset", 64'(data_o), 64'd0);
    rstn = 1'b1;
    run_vec("after reset", 8'd1, 8'd2, 8'd3, {NO{8'h6C}}, {NO{8'h6C}});
    check("reset total pulses", 64'(pulses - p0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
